// File: rtl/sd_sample_player.sv
// SD playback stage: fetches sectors into a ring buffer and releases one 13-bit sample per tick.
// Optional build macro SD_PLAY_LOOP_EN makes the recording loop forever instead of draining once.
module sd_sample_player #(
  parameter int unsigned CLK_DIV   = 200000,
  parameter int unsigned SEC_WORDS = 256,
  parameter int unsigned BUF_AW    = 9,
  parameter logic [31:0] START_SEC = 32'd16000,
  parameter int unsigned NUM_SEC   = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              play_start,
  input  logic              play_stop,
  input  logic              rd_busy,
  input  logic              rd_val_en,
  input  logic [15:0]       rd_val_data,
  output logic              rd_start_en,
  output logic [31:0]       rd_sec_addr,
  output logic              out_valid,
  output logic [12:0]       out_data,
  output logic              play_busy,
  output logic              play_done,
  output logic              underrun,
  output logic              overflow,
  output logic [BUF_AW:0]   buf_level
);

  localparam int unsigned DEPTH = 2 ** BUF_AW;
  localparam int unsigned LW    = BUF_AW + 1;
  localparam int unsigned TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW    = $clog2(NUM_SEC + 1);

  localparam logic [LW-1:0]     DEPTH_L     = LW'(DEPTH);
  localparam logic [LW-1:0]     SEC_WORDS_L = LW'(SEC_WORDS);
  localparam logic [LW-1:0]     LVL_ONE     = LW'(1);
  localparam logic [BUF_AW-1:0] PTR_ONE     = BUF_AW'(1);
  localparam logic [TW-1:0]     TICK_LAST   = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0]     TICK_ONE    = TW'(1);
  localparam logic [SW-1:0]     NUM_SEC_L   = SW'(NUM_SEC);
  localparam logic [SW-1:0]     SEC_ONE     = SW'(1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_BSY = 3'd2,
    ST_WAIT_END = 3'd3,
    ST_PLAY     = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_ABORT    = 3'd6
  } state_t;

  state_t             state_r;
  state_t             state_n;
  state_t             fsm_n_s;

  logic [12:0]        mem_r [DEPTH];
  logic [BUF_AW-1:0]  wr_ptr_r;
  logic [BUF_AW-1:0]  rd_ptr_r;
  logic [LW-1:0]      level_r;
  logic [TW-1:0]      tick_cnt_r;
  logic [SW-1:0]      sec_cnt_r;
  logic [31:0]        sec_addr_r;
  logic               primed_r;

  logic               rd_start_en_r;
  logic               out_valid_r;
  logic [12:0]        out_data_r;
  logic               play_busy_r;
  logic               play_done_r;
  logic               underrun_r;
  logic               overflow_r;

  logic               start_s;
  logic               sec_end_raw_s;
  logic               sec_end_s;
  logic               done_raw_s;
  logic               done_s;
  logic               to_idle_s;
  logic               clear_s;
  logic               last_sec_s;
  logic [SW-1:0]      sec_next_s;
  logic [LW-1:0]      free_s;
  logic               empty_s;
  logic               full_s;
  logic               push_s;
  logic               wr_s;
  logic               tick_en_s;
  logic               tick_s;
  logic               pop_s;
  logic               underrun_set_s;
  logic [2:0]         unused_hi_s;

  // States in which returned words are accepted and an empty tick counts as an underrun.
  function automatic logic is_stream(input state_t s);
    case (s)
      ST_REQ, ST_WAIT_BSY, ST_WAIT_END, ST_PLAY: is_stream = 1'b1;
      default:                                   is_stream = 1'b0;
    endcase
  endfunction

  assign unused_hi_s    = rd_val_data[15:13];
  assign empty_s        = (level_r == {LW{1'b0}});
  assign full_s         = (level_r == DEPTH_L);
  assign free_s         = DEPTH_L - level_r;
  assign sec_next_s     = sec_cnt_r + SEC_ONE;
  assign last_sec_s     = (sec_next_s == NUM_SEC_L);
  assign push_s         = rd_val_en && is_stream(state_r);
  assign wr_s           = push_s && !full_s;
  assign tick_en_s      = primed_r && (state_r != ST_IDLE) && (state_r != ST_ABORT);
  assign tick_s         = tick_en_s && (tick_cnt_r == TICK_LAST);
  assign to_idle_s      = (state_r != ST_IDLE) && (state_n == ST_IDLE);
  assign clear_s        = start_s || to_idle_s;
  assign pop_s          = tick_s && !empty_s && (state_n != ST_IDLE);
  assign underrun_set_s = tick_s && empty_s && is_stream(state_r);

  // Next-state logic; play_stop overrides every transition outside IDLE.
  always_comb begin
    fsm_n_s       = state_r;
    state_n       = state_r;
    start_s       = 1'b0;
    sec_end_raw_s = 1'b0;
    sec_end_s     = 1'b0;
    done_raw_s    = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (play_start) begin
          start_s = 1'b1;
          fsm_n_s = ST_REQ;
        end else begin
          fsm_n_s = ST_IDLE;
        end
      end
      ST_REQ: fsm_n_s = ST_WAIT_BSY;
      ST_WAIT_BSY: begin
        if (rd_busy) fsm_n_s = ST_WAIT_END;
        else         fsm_n_s = ST_WAIT_BSY;
      end
      ST_WAIT_END: begin
        if (!rd_busy) begin
          sec_end_raw_s = 1'b1;
          if (last_sec_s) begin
`ifdef SD_PLAY_LOOP_EN
            fsm_n_s = ST_PLAY;
`else
            fsm_n_s = ST_DRAIN;
`endif
          end else begin
            fsm_n_s = ST_PLAY;
          end
        end else begin
          fsm_n_s = ST_WAIT_END;
        end
      end
      ST_PLAY: begin
        if (free_s >= SEC_WORDS_L) fsm_n_s = ST_REQ;
        else                       fsm_n_s = ST_PLAY;
      end
      ST_DRAIN: begin
        if (empty_s) begin
          done_raw_s = 1'b1;
          fsm_n_s    = ST_IDLE;
        end else begin
          fsm_n_s    = ST_DRAIN;
        end
      end
      ST_ABORT: begin
        if (!rd_busy) fsm_n_s = ST_IDLE;
        else          fsm_n_s = ST_ABORT;
      end
      default: fsm_n_s = ST_IDLE;
    endcase

    if ((state_r != ST_IDLE) && play_stop) begin
      state_n = rd_busy ? ST_ABORT : ST_IDLE;
    end else begin
      state_n   = fsm_n_s;
      sec_end_s = sec_end_raw_s;
      done_s    = done_raw_s;
    end
  end

  // State register and registered strobes/sample output.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_r       <= ST_IDLE;
      rd_start_en_r <= 1'b0;
      play_busy_r   <= 1'b0;
      play_done_r   <= 1'b0;
      out_valid_r   <= 1'b0;
      out_data_r    <= 13'd0;
    end else begin
      state_r       <= state_n;
      rd_start_en_r <= (state_n == ST_REQ);
      play_busy_r   <= (state_n != ST_IDLE);
      play_done_r   <= done_s;
      out_valid_r   <= pop_s;
      if (pop_s) out_data_r <= mem_r[rd_ptr_r];
    end
  end

  // Ring buffer storage; no reset needed since level gates every read.
  always_ff @(posedge sys_clk) begin
    if (wr_s) mem_r[wr_ptr_r] <= rd_val_data[12:0];
  end

  // Buffer pointers, fill level and sample-rate divider.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_r   <= {BUF_AW{1'b0}};
      rd_ptr_r   <= {BUF_AW{1'b0}};
      level_r    <= {LW{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
    end else if (clear_s) begin
      wr_ptr_r   <= {BUF_AW{1'b0}};
      rd_ptr_r   <= {BUF_AW{1'b0}};
      level_r    <= {LW{1'b0}};
      tick_cnt_r <= {TW{1'b0}};
    end else begin
      if (wr_s)  wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      case ({wr_s, pop_s})
        2'b10:   level_r <= level_r + LVL_ONE;
        2'b01:   level_r <= level_r - LVL_ONE;
        default: level_r <= level_r;
      endcase
      if (tick_en_s) begin
        if (tick_s) tick_cnt_r <= {TW{1'b0}};
        else        tick_cnt_r <= tick_cnt_r + TICK_ONE;
      end
    end
  end

  // Sector sequencing, priming and sticky error flags.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sec_cnt_r  <= {SW{1'b0}};
      sec_addr_r <= START_SEC;
      primed_r   <= 1'b0;
      underrun_r <= 1'b0;
      overflow_r <= 1'b0;
    end else if (start_s) begin
      sec_cnt_r  <= {SW{1'b0}};
      sec_addr_r <= START_SEC;
      primed_r   <= 1'b0;
      underrun_r <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (to_idle_s) begin
        primed_r <= 1'b0;
      end else if (sec_end_s) begin
        primed_r <= 1'b1;
      end
      if (sec_end_s) begin
`ifdef SD_PLAY_LOOP_EN
        if (last_sec_s) begin
          sec_cnt_r  <= {SW{1'b0}};
          sec_addr_r <= START_SEC;
        end else begin
          sec_cnt_r  <= sec_next_s;
          sec_addr_r <= sec_addr_r + 32'd1;
        end
`else
        sec_cnt_r  <= sec_next_s;
        sec_addr_r <= sec_addr_r + 32'd1;
`endif
      end
      if (underrun_set_s)    underrun_r <= 1'b1;
      if (push_s && full_s)  overflow_r <= 1'b1;
    end
  end

  assign rd_start_en = rd_start_en_r;
  assign rd_sec_addr = sec_addr_r;
  assign out_valid   = out_valid_r;
  assign out_data    = out_data_r;
  assign play_busy   = play_busy_r;
  assign play_done   = play_done_r;
  assign underrun    = underrun_r;
  assign overflow    = overflow_r;
  assign buf_level   = level_r;

endmodule

// File: tb/tb_sd_sample_player.sv
// Directed bench for sd_sample_player with a behavioural SD read model.
// Define SD_PLAY_LOOP_EN for both files to exercise the looping build.
module tb_sd_sample_player;

  localparam int          CLK_DIV   = 4;
  localparam int          SEC_WORDS = 8;
  localparam int          BUF_AW    = 4;
  localparam int          NUM_SEC   = 3;
  localparam logic [31:0] START_SEC = 32'd100;

  logic              sys_clk;
  logic              sys_rst;
  logic              play_start;
  logic              play_stop;
  logic              rd_busy;
  logic              rd_val_en;
  logic [15:0]       rd_val_data;
  logic              rd_start_en;
  logic [31:0]       rd_sec_addr;
  logic              out_valid;
  logic [12:0]       out_data;
  logic              play_busy;
  logic              play_done;
  logic              underrun;
  logic              overflow;
  logic [BUF_AW:0]   buf_level;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc;
  logic [12:0] samp_q [$];
  int          samp_t [$];
  logic [31:0] req_q [$];
  int          done_cnt;
  int          max_level;
  int          n_words   = 8;
  int          stall_req = 0;
  int          stall_len = 0;

  sd_sample_player #(
    .CLK_DIV   (CLK_DIV),
    .SEC_WORDS (SEC_WORDS),
    .BUF_AW    (BUF_AW),
    .START_SEC (START_SEC),
    .NUM_SEC   (NUM_SEC)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst     (sys_rst),
    .play_start  (play_start),
    .play_stop   (play_stop),
    .rd_busy     (rd_busy),
    .rd_val_en   (rd_val_en),
    .rd_val_data (rd_val_data),
    .rd_start_en (rd_start_en),
    .rd_sec_addr (rd_sec_addr),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .play_busy   (play_busy),
    .play_done   (play_done),
    .underrun    (underrun),
    .overflow    (overflow),
    .buf_level   (buf_level)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge sys_clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    play_start = 1'b1;
    step(1);
    play_start = 1'b0;
  endtask

  task automatic pulse_stop();
    play_stop = 1'b1;
    step(1);
    play_stop = 1'b0;
  endtask

  task automatic wait_busy(input string tag, input logic lvl, input int budget);
    for (int c = 0; c < budget && rd_busy !== lvl; c++) step(1);
    check(tag, rd_busy, lvl);
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int c = 0; c < budget && play_busy !== 1'b0; c++) step(1);
    check(tag, play_busy, 1'b0);
  endtask

  task automatic wait_samples(input int n, input int budget);
    for (int c = 0; c < budget && samp_q.size() < n; c++) step(1);
  endtask

  task automatic wait_done(input int db, input int budget);
    for (int c = 0; c < budget && done_cnt == db; c++) step(1);
  endtask

  // Output monitor: captures samples with their cycle stamp, done pulses, peak fill per run.
  initial begin
    done_cnt  = 0;
    max_level = 0;
    forever begin
      @(negedge sys_clk);
      if (out_valid) begin
        samp_q.push_back(out_data);
        samp_t.push_back(cyc);
      end
      if (play_done) done_cnt++;
      if (play_start) max_level = 0;
      else if (int'(buf_level) > max_level) max_level = int'(buf_level);
    end
  end

  // SD controller model: busy follows a request, then n_words words, optional stall first.
  initial begin
    int run_req;
    run_req     = 0;
    rd_busy     = 1'b0;
    rd_val_en   = 1'b0;
    rd_val_data = 16'd0;
    forever begin
      @(negedge sys_clk);
      if (play_start) run_req = 0;
      if (rd_start_en && !sys_rst) begin
        req_q.push_back(rd_sec_addr);
        run_req++;
        rd_busy = 1'b1;
        if (run_req == stall_req) begin
          for (int c = 0; c < stall_len && !sys_rst; c++) @(negedge sys_clk);
        end
        for (int w = 0; w < n_words && !sys_rst; w++) begin
          rd_val_en   = 1'b1;
          rd_val_data = {3'b101, 13'(w + 1)};
          @(negedge sys_clk);
        end
        rd_val_en   = 1'b0;
        rd_val_data = 16'd0;
        rd_busy     = 1'b0;
      end
    end
  end

  initial begin
    int sb;
    int rb;
    int db;
    sys_rst    = 1'b1;
    play_start = 1'b0;
    play_stop  = 1'b0;
    step(3);
    check("rst_start_en", rd_start_en, 1'b0);
    check("rst_sec_addr", rd_sec_addr, 32'd100);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_play_busy", play_busy, 1'b0);
    check("rst_play_done", play_done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_buf_level", buf_level, 32'd0);
    sys_rst = 1'b0;
    step(2);

`ifndef SD_PLAY_LOOP_EN
    // Normal single pass: 3 sectors of 1..8, one sample every 4 cycles.
    sb = samp_q.size(); rb = req_q.size(); db = done_cnt;
    pulse_start();
    check("norm_busy", play_busy, 1'b1);
    wait_done(db, 600);
    step(5);
    check("norm_n_samples", samp_q.size() - sb, 32'd24);
    for (int k = 0; k < 24 && sb + k < samp_q.size(); k++)
      check($sformatf("norm_sample%0d", k), samp_q[sb + k], (k % 8) + 1);
    for (int k = 1; k < 24 && sb + k < samp_q.size(); k++)
      check($sformatf("norm_gap%0d", k), samp_t[sb + k] - samp_t[sb + k - 1], 32'd4);
    check("norm_n_req", req_q.size() - rb, 32'd3);
    for (int i = 0; i < 3 && rb + i < req_q.size(); i++)
      check($sformatf("norm_req%0d", i), req_q[rb + i], 32'd100 + i);
    check("norm_done_cnt", done_cnt - db, 32'd1);
    check("norm_underrun", underrun, 1'b0);
    check("norm_overflow", overflow, 1'b0);
    check("norm_idle", play_busy, 1'b0);
    check("norm_level", buf_level, 32'd0);
    check("norm_hold", out_data, 32'd8);
    check("norm_end_addr", rd_sec_addr, 32'd103);
`endif

    // Reset asserted in the middle of playback.
    sb = samp_q.size();
    pulse_start();
    wait_samples(sb + 3, 300);
    check("midrst_samples", samp_q.size() >= sb + 3, 1'b1);
    sys_rst = 1'b1;
    step(1);
    check("midrst_addr", rd_sec_addr, 32'd100);
    check("midrst_busy", play_busy, 1'b0);
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_data", out_data, 32'd0);
    check("midrst_level", buf_level, 32'd0);
    check("midrst_start_en", rd_start_en, 1'b0);
    step(2);
    sys_rst = 1'b0;
    step(1);
    check("midrst_idle", play_busy, 1'b0);
    wait_busy("midrst_model_idle", 1'b0, 20);
    step(2);

    // Abort while the SD read is still busy; words during ABORT are discarded.
    stall_req = 1; stall_len = 20;
    sb = samp_q.size(); rb = req_q.size(); db = done_cnt;
    pulse_start();
    wait_busy("abort_busy_seen", 1'b1, 10);
    step(3);
    pulse_stop();
    check("abort_state_busy", play_busy, 1'b1);
    check("abort_rd_busy", rd_busy, 1'b1);
    wait_idle("abort_idle", 100);
    check("abort_rd_done", rd_busy, 1'b0);
    check("abort_max_level", max_level, 32'd0);
    check("abort_samples", samp_q.size() - sb, 32'd0);
    check("abort_no_done", done_cnt - db, 32'd0);
    check("abort_n_req", req_q.size() - rb, 32'd1);
    stall_req = 0;
    step(2);

`ifndef SD_PLAY_LOOP_EN
    // Second sector stalls for 200 cycles: buffer runs dry after word 8.
    stall_req = 2; stall_len = 200;
    sb = samp_q.size(); rb = req_q.size(); db = done_cnt;
    pulse_start();
    wait_samples(sb + 8, 300);
    step(20);
    check("stall_underrun", underrun, 1'b1);
    check("stall_hold", out_data, 32'd8);
    check("stall_n_samples", samp_q.size() - sb, 32'd8);
    check("stall_rd_busy", rd_busy, 1'b1);
    check("stall_first_req", req_q[rb], 32'd100);
    wait_done(db, 1500);
    step(3);
    check("stall_total", samp_q.size() - sb, 32'd24);
    for (int k = 0; k < 24 && sb + k < samp_q.size(); k++)
      check($sformatf("stall_sample%0d", k), samp_q[sb + k], (k % 8) + 1);
    check("stall_done_cnt", done_cnt - db, 32'd1);
    check("stall_sticky", underrun, 1'b1);
    stall_req = 0;
    step(2);
`endif

    // 17-word burst into an empty 16-word buffer.
    n_words = 17;
    sb = samp_q.size();
    pulse_start();
    check("ovf_underrun_clr", underrun, 1'b0);
    wait_busy("ovf_busy_hi", 1'b1, 10);
    wait_busy("ovf_busy_lo", 1'b0, 50);
    step(1);
    check("ovf_level", buf_level, 32'd16);
    check("ovf_flag", overflow, 1'b1);
    wait_samples(sb + 1, 20);
    check("ovf_first", samp_q.size() > sb ? samp_q[sb] : 13'd0, 32'd1);
    pulse_stop();
    step(1);
    check("ovf_idle", play_busy, 1'b0);
    check("ovf_cleared", buf_level, 32'd0);
    check("ovf_sticky", overflow, 1'b1);
    n_words = 8;
    step(2);

`ifdef SD_PLAY_LOOP_EN
    // Looping build: sector address wraps to 100 after 102 and playback never completes.
    sb = samp_q.size(); rb = req_q.size(); db = done_cnt;
    pulse_start();
    wait_samples(sb + 40, 2000);
    check("loop_n_samples", samp_q.size() >= sb + 40, 1'b1);
    for (int k = 0; k < 40 && sb + k < samp_q.size(); k++)
      check($sformatf("loop_sample%0d", k), samp_q[sb + k], (k % 8) + 1);
    check("loop_n_req", req_q.size() >= rb + 4, 1'b1);
    for (int i = 0; i < 4 && rb + i < req_q.size(); i++)
      check($sformatf("loop_req%0d", i), req_q[rb + i], 32'd100 + (i % 3));
    check("loop_no_done", done_cnt - db, 32'd0);
    pulse_stop();
    wait_idle("loop_idle", 100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
